// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Status bit positions describe the 32-bit word the CPU reads.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam int NOT_EMPTY_BIT = 15;
  localparam int OVERFLOW_BIT  = 14;
  localparam int FRAME_ERR_BIT = 13;
  localparam int COUNT_LSB     = 8;
  localparam int COUNT_W       = 5;
  localparam int FRAME_BITS    = 8;

  // Odd parity holds when the data ones plus the parity bit sum to an odd number.
  function automatic logic odd_parity_ok(input logic data_acc, input logic parity_bit);
    return data_acc ^ parity_bit;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Small synchronous scan-code FIFO with a combinational head and a drop pulse
// for pushes that arrive while full with no pop in the same cycle.
module ps2_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head,
  output logic             dropped
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty;
    // A pop frees the slot this same cycle, so a full FIFO can still accept.
    do_push  = push & (~full | do_pop);
    dropped  = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/ps2_kbd_dev_io.sv
// PS/2 keyboard receiver: synchronise and filter the pins, deframe 11-bit
// frames, queue good scan codes and expose head byte plus status to the bus.
module ps2_kbd_dev_io
  import ps2_kbd_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        kbd_rd,
  input  logic        kbd_clr,
  output logic [31:0] kbd_data_out,
  output logic        kbd_int
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic             fall_edge;

  ps2_state_e       state_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             par_acc_q, par_ok_q;
  logic [TOW-1:0]   to_cnt_q;
  logic             timeout_hit;

  logic             push, frame_err_set;
  logic             fifo_full, fifo_empty, fifo_dropped;
  logic [FCNT_W-1:0] fifo_count;
  logic [7:0]       fifo_head;
  logic             overflow_q, overflow_d, frame_err_q, frame_err_d;

  // Two-flop synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      clk_meta_q  <= ps2_clk;
      clk_sync_q  <= clk_meta_q;
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  // Filter flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  assign fall_edge = filt_prev_q & ~filt_q;

  assign timeout_hit = (state_q != ST_IDLE) && !fall_edge &&
                       (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      par_ok_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      if (state_q == ST_IDLE || fall_edge) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (timeout_hit) begin
        state_q <= ST_IDLE;
      end else if (fall_edge) begin
        case (state_q)
          ST_IDLE: begin
            if (!data_sync_q) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
              par_acc_q <= 1'b0;
            end
          end
          ST_DATA: begin
            shift_q   <= {data_sync_q, shift_q[7:1]};
            par_acc_q <= par_acc_q ^ data_sync_q;
            if (bit_idx_q == 3'(FRAME_BITS - 1)) begin
              state_q <= ST_PARITY;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
          ST_PARITY: begin
            par_ok_q <= odd_parity_ok(par_acc_q, data_sync_q);
            state_q  <= ST_STOP;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // The stop-bit edge decides the frame in the same cycle so the byte lands next clock.
  always_comb begin
    push          = 1'b0;
    frame_err_set = timeout_hit;
    if (fall_edge && state_q == ST_STOP) begin
      if (data_sync_q && par_ok_q) begin
        push = 1'b1;
      end else begin
        frame_err_set = 1'b1;
      end
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     (shift_q),
    .pop     (kbd_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head),
    .dropped (fifo_dropped)
  );

  // A set event in the clear cycle wins.
  always_comb begin
    overflow_d  = fifo_dropped  ? 1'b1 : (kbd_clr ? 1'b0 : overflow_q);
    frame_err_d = frame_err_set ? 1'b1 : (kbd_clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    kbd_data_out                          = '0;
    kbd_data_out[7:0]                     = fifo_head;
    kbd_data_out[COUNT_LSB +: COUNT_W]    = COUNT_W'(fifo_count);
    kbd_data_out[FRAME_ERR_BIT]           = frame_err_q;
    kbd_data_out[OVERFLOW_BIT]            = overflow_q;
    kbd_data_out[NOT_EMPTY_BIT]           = ~fifo_empty;
    kbd_int                               = ~fifo_empty;
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ps2_kbd_dev_io.sv
// Directed plus randomized bench for the PS/2 keyboard receiver, checked
// against a queue-based model of the keyboard FIFO and sticky flags.
module tb_ps2_kbd_dev_io;
  import ps2_kbd_pkg::*;

  localparam int FILT  = 8;
  localparam int TMO   = 300;
  localparam int DEPTH = 8;
  localparam int HALF  = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        kbd_rd = 1'b0;
  logic        kbd_clr = 1'b0;
  logic [31:0] kbd_data_out;
  logic        kbd_int;

  int n_asserts = 0;
  int n_fail = 0;

  logic [7:0] mq[$];
  bit         m_ovf = 1'b0;
  bit         m_ferr = 1'b0;

  always #5 clk = ~clk;

  ps2_kbd_dev_io #(
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .kbd_rd       (kbd_rd),
    .kbd_clr      (kbd_clr),
    .kbd_data_out (kbd_data_out),
    .kbd_int      (kbd_int)
  );

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = 32'h0;
    if (mq.size() != 0) begin
      w[7:0] = mq[0];
      w[15]  = 1'b1;
    end
    w[12:8] = 5'(mq.size());
    w[14]   = m_ovf;
    w[13]   = m_ferr;
    return w;
  endfunction

  // kind: 0 = good frame, 1 = bad parity, 2 = bad stop
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = ~(^b) ^ (kind == 1);
    f[10]   = (kind != 2);
    return f;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input int kind);
    if (kind != 0) begin
      m_ferr = 1'b1;
    end else if (mq.size() < DEPTH) begin
      mq.push_back(b);
    end else begin
      m_ovf = 1'b1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] w;
    w = model_word();
    chk(tag, kbd_data_out, w);
    chk({tag, "_int"}, {31'b0, kbd_int}, {31'b0, w[15]});
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive nbits frame bits, LSB (start) first; optional short clock glitch in bit 4's high phase.
  task automatic send_raw(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      if (glitch && i == 4) begin
        wait_cyc(14);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 17);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind);
    send_raw(mk_frame(b, kind), 11, 1'b0);
    model_frame(b, kind);
  endtask

  task automatic pop_one();
    @(negedge clk);
    kbd_rd = 1'b1;
    @(negedge clk);
    kbd_rd = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic clr_flags();
    @(negedge clk);
    kbd_clr = 1'b1;
    @(negedge clk);
    kbd_clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         kind;
    bit         seen;

    wait_cyc(4);
    chk_all("reset");
    rst_n = 1'b1;
    wait_cyc(4);
    chk_all("post_reset");

    send_frame(8'h1C, 0);
    chk("good_1c", kbd_data_out, 32'h0000_811C);
    chk_all("good_1c_m");
    pop_one();
    chk("pop_1c", kbd_data_out, 32'h0000_0000);
    chk_all("pop_1c_m");

    send_frame(8'h1C, 1);
    chk("bad_parity", kbd_data_out, 32'h0000_2000);
    clr_flags();
    chk("clr", kbd_data_out, 32'h0000_0000);

    send_frame(8'h1C, 2);
    chk_all("bad_stop");
    clr_flags();

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    chk("ovf_full", kbd_data_out, 32'h0000_C801);
    for (int i = 1; i <= 8; i++) begin
      chk_all($sformatf("ovf_pop%0d", i));
      pop_one();
    end
    chk_all("ovf_empty");
    clr_flags();
    chk_all("ovf_clr");

    send_raw(mk_frame(8'hA5, 0), 5, 1'b0);
    wait_cyc(TMO + 10);
    m_ferr = 1'b1;
    chk_all("timeout");
    chk("timeout_idle", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    send_frame(8'h5A, 0);
    chk_all("after_tmo_5a");
    pop_one();
    clr_flags();

    send_raw(mk_frame(8'hF0, 0), 11, 1'b1);
    model_frame(8'hF0, 0);
    chk_all("glitch_f0");
    pop_one();

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0);
    chk_all("fill8");
    b = 8'($urandom_range(0, 255));
    seen = 1'b0;
    fork
      send_raw(mk_frame(b, 0), 11, 1'b0);
      begin
        for (int c = 0; c < 2000 && !seen; c++) begin
          @(negedge clk);
          if (dut.fall_edge === 1'b1 && dut.state_q == ST_STOP) begin
            kbd_rd = 1'b1;
            @(negedge clk);
            kbd_rd = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    chk("sim_seen", {31'b0, seen}, 32'h1);
    void'(mq.pop_front());
    mq.push_back(b);
    chk_all("sim_push_pop");
    while (mq.size() != 0) begin
      chk_all("sim_drain");
      pop_one();
    end

    for (int i = 0; i < 14; i++) begin
      b = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 4);
      if (kind > 2) kind = 0;
      send_frame(b, kind);
      chk_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        chk_all($sformatf("rnd%0d_pop", i));
      end
      if ($urandom_range(0, 3) == 0) begin
        clr_flags();
        chk_all($sformatf("rnd%0d_clr", i));
      end
    end

    if (mq.size() == 0) begin
      send_frame(8'h33, 0);
    end
    send_raw(mk_frame(8'h77, 0), 4, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    chk("rst_out", kbd_data_out, 32'h0);
    chk("rst_int", {31'b0, kbd_int}, 32'h0);
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h29, 0);
    chk("after_rst_29", kbd_data_out, 32'h0000_8129);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
